uart_tx_wrapper: RTL and testbench
==================================

UART_TX_WRAPPER -- requirements
Module: uart_tx_wrapper

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, sets system clock cycles per serial bit (100 MHz / 115200 baud); legal values are 2 or greater.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the transmit buffer entries; legal values are powers of two, 2 or greater.
REQ-003 Port I_sys_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port I_sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port I_tx_data, input, 8 bits: byte to transmit (move or status code).
REQ-006 Port I_tx_valid, input, 1 bit: I_tx_data is valid this cycle.
REQ-007 Port o_tx_ready, output, 1 bit: FIFO can accept a byte this cycle.
REQ-008 Port o_tx_serial, output, 1 bit: UART line output; it idles high.
REQ-009 Port o_tx_busy, output, 1 bit: a frame is in progress (FSM is not in IDLE).
REQ-010 Port o_tx_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-011 Port o_fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of bytes queued.

Function
REQ-012 A byte is pushed when I_tx_valid and o_tx_ready are both high on a clock edge; I_tx_valid while o_tx_ready is low is ignored and does not stall or corrupt state.
REQ-013 o_tx_ready equals (o_fifo_count < FIFO_DEPTH) and is computed combinationally from the registered count.
REQ-014 A push and a pop in the same cycle leave the count unchanged. When the FIFO is full, o_tx_ready stays low even if a pop occurs that cycle.
REQ-015 The FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: o_tx_serial is 1. If the FIFO is non-empty, pop the head byte into the shift register and go to START on the next edge.
REQ-017 START: o_tx_serial is 0 for exactly CLKS_PER_BIT cycles.
REQ-018 DATA: bits are sent LSB first, each for CLKS_PER_BIT cycles; a 3-bit bit index wraps from 7 to exit the state.
REQ-019 After DATA, the FSM goes to PARITY if it is compiled in (REQ-027), otherwise to STOP.
REQ-020 STOP: o_tx_serial is 1 for CLKS_PER_BIT cycles. o_tx_done is high during the final stop cycle, then the FSM returns to IDLE.
REQ-021 Back-to-back frames are separated by exactly one IDLE cycle, with the line high.
REQ-022 The baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0 to CLKS_PER_BIT-1, and restarts at each state entry.
REQ-023 o_tx_serial is registered (no combinational glitches).
REQ-024 Frame latency: the start bit begins 2 cycles after the push edge when the FSM is idle and the FIFO is empty.

Reset
REQ-025 On I_sys_rst high, immediately and independent of the clock: FSM goes to IDLE; o_tx_serial is 1; o_tx_busy and o_tx_done are 0; FIFO pointers and count are 0 (o_tx_ready is 1).
REQ-026 Reset mid-frame aborts the frame, drives the line high immediately, and discards all queued bytes. The first edge after release can accept a push.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, the PARITY state sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving an 11-bit frame. When undefined, the PARITY state and its logic are absent and the frame is 8N1 (10 bits).

Structure
REQ-028 Package uart_pkg holds the tx_state_t enum (IDLE, START, DATA, PARITY, STOP), UART_DATA_W = 8, and the IDLE_LINE = 1 constant. The matching receiver shares this package.
REQ-029 Sub-module uart_tx_fifo (synchronous FIFO with push, pop, count, full, empty) is instantiated once. The FSM, baud counter, and shifter are in uart_tx_wrapper.

Verification
REQ-030 With CLKS_PER_BIT=4 and no parity, push 0xA5 into an idle block. Required: line sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles; start bit 2 cycles after the push; o_tx_done pulses once.
REQ-031 Push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles with FIFO_DEPTH=4. Required: o_tx_ready drops when count reaches 4; a refused byte is never sent; sent bytes match push order; 1 idle cycle between frames.
REQ-032 With the FIFO full, assert push and pop in the same cycle. Required: the push is refused and the count becomes 3.
REQ-033 Assert I_sys_rst midway through the DATA state with 2 bytes queued. Required: o_tx_serial is 1 before the next edge; count is 0; after release, a push of 0x3C transmits cleanly.
REQ-034 With UART_TX_PARITY_EN defined, push 0x07 and then 0x03. Required: parity bits 1 and 0 respectively; 11-bit frames, each bit 4 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and the matching receiver.
//   tx_state_t  : transmitter FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   UART_DATA_W : payload width of one serial frame
//   IDLE_LINE   : level of the serial line when no frame is in progress
//   even_parity : even-parity bit for one payload byte
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_W = 8;
    localparam logic IDLE_LINE   = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Even parity: the XOR of all data bits, so the total count of ones is even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO buffering bytes for the transmitter.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, empties the FIFO
//   push_i  : write data_i (ignored when full)
//   data_i  : write data
//   pop_i   : drop the head entry (ignored when empty)
//   data_o  : head entry, valid whenever empty_o is low
//   count_o : number of stored entries, 0..DEPTH
//   full_o  : count_o == DEPTH
//   empty_o : count_o == 0
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_wrapper.sv
// -----------------------------------------------------------------------------
// uart_tx_wrapper
// Buffered UART transmitter: byte FIFO in front of a start/data/stop framer.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit (8E1 frame);
// without it the frame is 8N1.
// Parameters:
//   CLKS_PER_BIT : system clocks per serial bit (>= 2)
//   FIFO_DEPTH   : transmit buffer entries (power of two, >= 2)
// Ports:
//   I_sys_clk    : system clock, rising edge
//   I_sys_rst    : asynchronous active-high reset; aborts any frame, empties FIFO
//   I_tx_data    : byte to queue
//   I_tx_valid   : I_tx_data valid; accepted only together with o_tx_ready
//   o_tx_ready   : FIFO has room this cycle
//   o_tx_serial  : registered UART line, idles high
//   o_tx_busy    : framer is not idle
//   o_tx_done    : one-cycle pulse during the final stop-bit cycle on the line
//   o_fifo_count : number of queued bytes
// -----------------------------------------------------------------------------
module uart_tx_wrapper
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          I_sys_clk,
    input  logic                          I_sys_rst,
    input  logic [UART_DATA_W-1:0]        I_tx_data,
    input  logic                          I_tx_valid,
    output logic                          o_tx_ready,
    output logic                          o_tx_serial,
    output logic                          o_tx_busy,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   serial_q, serial_d;
    logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic                   push_s;
    logic                   pop_s;
    logic                   baud_last_s;
    logic [UART_DATA_W-1:0] head_s;
    logic                   full_s;
    logic                   empty_s;

    // full means count == FIFO_DEPTH, so this is count < FIFO_DEPTH from the
    // registered count: a pop in the same cycle does not reopen a full FIFO.
    assign o_tx_ready  = ~full_s;
    assign push_s      = I_tx_valid && o_tx_ready;
    assign baud_last_s = (baud_q == BAUD_LAST);

    assign o_tx_serial = serial_q;
    assign o_tx_done   = done_q;
    assign o_tx_busy   = (state_q != IDLE);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk_i   (I_sys_clk),
        .rst_i   (I_sys_rst),
        .push_i  (push_s),
        .data_i  (I_tx_data),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .count_o (o_fifo_count),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Framer next-state: state sequencing, baud timing, bit index and shifter.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    shift_d   = head_s;
`ifdef UART_TX_PARITY_EN
                    parity_d  = even_parity(head_s);
`endif
                    baud_d    = {BAUD_W{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = START;
                end else begin
                    state_d   = IDLE;
                end
            end
            START: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = DATA;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last_s) begin
                    baud_d    = {BAUD_W{1'b0}};
                    shift_d   = {1'b0, shift_q[UART_DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    // Leaving after bit 7, when the index wraps back to 0.
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = STOP;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_last_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                baud_d  = {BAUD_W{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the current state; registered below, so the line trails
    // the state by one cycle and done lines up with the last stop-bit cycle.
    always_comb begin
        serial_d = IDLE_LINE;
        case (state_q)
            IDLE:    serial_d = IDLE_LINE;
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_q;
`endif
            STOP:    serial_d = 1'b1;
            default: serial_d = IDLE_LINE;
        endcase
    end

    // Framer state and registered outputs.
    always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
        if (I_sys_rst) begin
            state_q   <= IDLE;
            baud_q    <= {BAUD_W{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= {UART_DATA_W{1'b0}};
            serial_q  <= IDLE_LINE;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_wrapper.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_wrapper
// Directed self-checking bench for uart_tx_wrapper with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. Frame length follows the UART_TX_PARITY_EN build macro.
// -----------------------------------------------------------------------------
module tb_uart_tx_wrapper;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int total;
    int bad;

    logic       exp_rdy_31 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_cnt_31 [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] bytes_32   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] exp_cnt_32 [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    uart_tx_wrapper #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .I_sys_clk    (clk),
        .I_sys_rst    (rst),
        .I_tx_data    (tx_data),
        .I_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_tx_serial  (tx_serial),
        .o_tx_busy    (tx_busy),
        .o_tx_done    (tx_done),
        .o_fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit k: start, data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) begin
            return 1'b0;
        end else if (k <= 8) begin
            return b[k-1];
        end
`ifdef UART_TX_PARITY_EN
        else if (k == 9) begin
            return ^b;
        end
`endif
        else begin
            return 1'b1;
        end
    endfunction

    // Checks frame samples skip..FRAME_CYC-1, the current sample being 'skip'.
    // Returns on the last stop-bit sample (no step after it).
    task automatic expect_frame(input logic [7:0] b, input int skip);
        for (int s = skip; s < FRAME_CYC; s++) begin
            chk($sformatf("line_%02h_s%0d", b, s), tx_serial, frame_bit(b, s / CPB));
            chk($sformatf("done_%02h_s%0d", b, s), tx_done, (s == FRAME_CYC - 1));
            if (s != FRAME_CYC - 1) step();
        end
    endtask

    // Steps to the inter-frame gap sample, checks it, steps onto the next start bit.
    task automatic gap_then_frame(input logic [7:0] b);
        step();
        chk($sformatf("gap_line_%02h", b), tx_serial, 1'b1);
        chk($sformatf("gap_done_%02h", b), tx_done, 1'b0);
        step();
        expect_frame(b, 0);
    endtask

    task automatic expect_quiet(input string tag);
        for (int i = 0; i < 12; i++) begin
            chk({tag, "_line"}, tx_serial, 1'b1);
            chk({tag, "_busy"}, tx_busy, 1'b0);
            step();
        end
        chk({tag, "_count"}, fifo_count, 3'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Asynchronous reset, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_line",  tx_serial,  1'b1);
        chk("rst_busy",  tx_busy,    1'b0);
        chk("rst_done",  tx_done,    1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ready", tx_ready,   1'b1);
        step();
        step();
        rst = 1'b0;

        // Single byte 0xA5 into an idle block: start bit 2 cycles after push.
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        step();
        tx_valid = 1'b0;
        chk("a5_count", fifo_count, 3'd1);
        chk("a5_lat0",  tx_serial,  1'b1);
        step();
        chk("a5_lat1",  tx_serial,  1'b1);
        chk("a5_busy",  tx_busy,    1'b1);
        step();
        expect_frame(8'hA5, 0);
        step();
        chk("a5_end_line",  tx_serial,  1'b1);
        chk("a5_end_busy",  tx_busy,    1'b0);
        chk("a5_end_done",  tx_done,    1'b0);
        chk("a5_end_count", fifo_count, 3'd0);

        // Six pushes on consecutive cycles: the sixth meets a full FIFO.
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fill_ready_%0d", i), tx_ready, exp_rdy_31[i]);
            tx_valid = 1'b1;
            tx_data  = 8'(i + 1);
            step();
            chk($sformatf("fill_count_%0d", i), fifo_count, exp_cnt_31[i]);
            chk($sformatf("fill_line_%0d", i), tx_serial, (i < 2) ? 1'b1 : 1'b0);
        end
        tx_valid = 1'b0;
        step();
        expect_frame(8'h01, 4);
        gap_then_frame(8'h02);
        gap_then_frame(8'h03);
        gap_then_frame(8'h04);
        gap_then_frame(8'h05);
        step();
        expect_quiet("fill_quiet");

        // Full FIFO with push and pop on the same edge: push refused, count 3.
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1;
            tx_data  = bytes_32[i];
            step();
            chk($sformatf("full_count_%0d", i), fifo_count, exp_cnt_32[i]);
        end
        tx_valid = 1'b0;
        expect_frame(8'h11, 2);
        chk("full_pre_count", fifo_count, 3'd4);
        chk("full_pre_ready", tx_ready,   1'b0);
        tx_valid = 1'b1;
        tx_data  = 8'h66;
        step();
        tx_valid = 1'b0;
        chk("full_pp_count", fifo_count, 3'd3);
        chk("full_pp_ready", tx_ready,   1'b1);
        chk("full_pp_gap",   tx_serial,  1'b1);
        step();
        expect_frame(8'h22, 0);
        gap_then_frame(8'h33);
        gap_then_frame(8'h44);
        gap_then_frame(8'h55);
        step();
        expect_quiet("full_quiet");

        // Reset in the middle of DATA with two bytes queued.
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        step();
        tx_data  = 8'h11;
        step();
        tx_data  = 8'h22;
        step();
        tx_valid = 1'b0;
        chk("mid_count", fifo_count, 3'd2);
        for (int s = 0; s < 18; s++) begin
            chk($sformatf("mid_line_s%0d", s), tx_serial, frame_bit(8'h5A, s / CPB));
            step();
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_line",  tx_serial,  1'b1);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_ready", tx_ready,   1'b1);
        chk("mid_rst_busy",  tx_busy,    1'b0);
        chk("mid_rst_done",  tx_done,    1'b0);
        step();
        step();
        rst      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        step();
        tx_valid = 1'b0;
        chk("post_count", fifo_count, 3'd1);
        chk("post_lat0",  tx_serial,  1'b1);
        step();
        chk("post_lat1",  tx_serial,  1'b1);
        step();
        expect_frame(8'h3C, 0);
        step();
        expect_quiet("post_quiet");

        // 0x07 then 0x03: parity bits 1 and 0 when parity is built in.
        tx_valid = 1'b1;
        tx_data  = 8'h07;
        step();
        tx_data  = 8'h03;
        step();
        tx_valid = 1'b0;
        chk("par_count", fifo_count, 3'd1);
        chk("par_lat1",  tx_serial,  1'b1);
        step();
        expect_frame(8'h07, 0);
        gap_then_frame(8'h03);
        step();
        expect_quiet("par_quiet");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
